exc_seq: RTL and testbench

- Exception/interrupt sequencer plus CP0 register file for the 5-stage MIPS32 core.
- Sits at the M stage; consumes ExcCode (bits [6:2]) accumulated from the F/D/E/M exception detectors.
- Decides when an exception or interrupt is taken, kills the pipeline, records EPC/Cause/SR and redirects fetch to the handler.
- Also sequences ERET and MFC0/MTC0 accesses.

---
 rtl/exc_seq.sv | 177 +++++++++++++++++
 tb/tb_exc_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_seq.sv
// Exception/interrupt sequencer and CP0 register file (SR, Cause, EPC, PRId) at the M stage.
// Optional exception counter at CP0 reg 22 is enabled by defining EXC_COUNT_EN.
module exc_seq #(
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL    = 32'h4D49_5053,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        m_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] ADDR_SR   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC  = 5'd14;
  localparam logic [4:0] ADDR_PRID = 5'd15;
  localparam logic [4:0] ADDR_CNT  = 5'd22;

  typedef enum logic [1:0] {RUN = 2'd0, INT_WAIT = 2'd1, ERET_HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  ip_sync;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cnt_rd;
  logic        int_pend, int_eff, exc_any, take, eret_go;

  // hw_int crosses into clk domain through a plain flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ip_sync  = sync_q[SYNC_STAGES-1];
  assign int_pend = (|(ip_sync & im_q)) & ie_q & ~exl_q;
  assign exc_any  = (m_exc_code != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Take/ERET decision; reset gates the combinational outputs immediately
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    eret_go = 1'b0;
    int_eff = int_pend;
    unique case (state_q)
      RUN: begin
        take    = ~exl_q & m_valid & (exc_any | int_pend);
        eret_go = m_eret & m_valid & ~take;
        if (eret_go)                  state_d = ERET_HOLD;
        else if (int_pend & ~m_valid) state_d = INT_WAIT;
      end
      INT_WAIT: begin
        take = ~exl_q & m_valid & (exc_any | int_pend);
        if (take || !int_pend) state_d = RUN;
      end
      ERET_HOLD: begin
        int_eff = 1'b0;
        take    = ~exl_q & m_valid & exc_any;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!reset) begin
      take    = 1'b0;
      eret_go = 1'b0;
    end
  end

  assign m_kill         = take;
  assign flush          = take | eret_go;
  assign redirect_valid = take | eret_go;
  assign redirect_pc    = !eret_go ? HANDLER_PC :
                          (cp0_we && cp0_addr == ADDR_EPC) ? cp0_wdata : epc_q;

  // A take owns the CP0 update; MTC0 in that cycle is dropped
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (take) begin
      exl_d = 1'b1;
      bd_d  = m_bd;
      epc_d = m_bd ? (m_pc - 32'd4) : m_pc;
      exc_d = int_eff ? 5'd0 : m_exc_code;
    end else begin
      if (cp0_we) begin
        unique case (cp0_addr)
          ADDR_SR: begin
            im_d  = cp0_wdata[15:10];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
          end
          ADDR_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
      if (eret_go) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

`ifdef EXC_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take)                                  cnt_d = cnt_q + 32'd1;
    else if (cp0_we && cp0_addr == ADDR_CNT)   cnt_d = cp0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = 32'd0;
`endif

  always_comb begin
    cp0_rdata = 32'd0;
    unique case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_sync, 3'd0, exc_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID_VAL;
      ADDR_CNT:   cp0_rdata = cnt_rd;
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_exc_seq.sv
// Scoreboard bench for exc_seq: expected outputs are queued as stimulus is driven and
// popped when the DUT outputs are sampled mid-cycle.
module tb_exc_seq;

  localparam logic [31:0] HPC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_bd, m_eret, cp0_we;
  logic [31:0] m_pc, cp0_wdata;
  logic [4:0]  m_exc_code, cp0_addr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata, redirect_pc;
  logic        m_kill, flush, redirect_valid;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  exc_seq dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc_code(m_exc_code), .m_eret(m_eret), .hw_int(hw_int), .cp0_we(cp0_we),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .m_kill(m_kill), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got %h expected <queued value>", got);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic bd, input logic [4:0] code,
                     input logic eret, input logic we, input logic [4:0] addr, input logic [31:0] wd);
    m_valid = v; m_pc = pc; m_bd = bd; m_exc_code = code; m_eret = eret;
    cp0_we = we; cp0_addr = addr; cp0_wdata = wd;
  endtask

  task automatic idle();
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic exp_out(input string tag, input logic kill, input logic redir, input logic [31:0] rpc);
    push({tag, ".kill"}, {31'd0, kill});
    push({tag, ".flush"}, {31'd0, redir});
    push({tag, ".rv"}, {31'd0, redir});
    push({tag, ".rpc"}, rpc);
    #1;
    pop_chk({31'd0, m_kill});
    pop_chk({31'd0, flush});
    pop_chk({31'd0, redirect_valid});
    pop_chk(redirect_pc);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] e);
    cp0_addr = a;
    push(tag, e);
    #1;
    pop_chk(cp0_rdata);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    hw_int = 6'd0;
    idle();
    exp_out("rst", 1'b0, 1'b0, HPC);
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    cyc();
    reset = 1'b1;

    // AdEL take
    drv(1'b1, 32'h2ffc, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("adel", 1'b1, 1'b1, HPC);
    cyc(); idle();
    rd(5'd14, "adel_epc", 32'h2ffc);
    rd(5'd13, "adel_cause", 32'h0000_0010);
    rd(5'd12, "adel_sr", 32'h0000_0002);

    // masked exception while EXL=1
    drv(1'b1, 32'h5000, 1'b0, 5'd10, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("masked", 1'b0, 1'b0, HPC);
    cyc(); idle();
    rd(5'd14, "masked_epc", 32'h2ffc);
    rd(5'd13, "masked_cause", 32'h0000_0010);

    // clear EXL, then delay-slot overflow
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'd0);
    exp_out("sr_clr", 1'b0, 1'b0, HPC);
    cyc();
    drv(1'b1, 32'h3010, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("ov_bd", 1'b1, 1'b1, HPC);
    cyc(); idle();
    rd(5'd14, "ov_epc", 32'h300c);
    rd(5'd13, "ov_cause", 32'h8000_0030);

    // interrupt arriving during bubbles
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0401);
    exp_out("sr_im", 1'b0, 1'b0, HPC);
    cyc(); idle();
    hw_int = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      exp_out($sformatf("bubble%0d", i), 1'b0, 1'b0, HPC);
      if (i == 2) rd(5'd13, "ip_live", 32'h8000_0430);
      cyc();
    end
    drv(1'b1, 32'h3020, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("int_take", 1'b1, 1'b1, HPC);
    cyc(); idle();
    rd(5'd14, "int_epc", 32'h3020);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd12, "int_sr", 32'h0000_0403);

    // ERET with same-cycle EPC write, then held interrupt
    drv(1'b1, 32'h4200, 1'b0, 5'd0, 1'b1, 1'b1, 5'd14, 32'h3100);
    exp_out("eret", 1'b0, 1'b1, 32'h3100);
    rd(5'd14, "eret_rdata_nofwd", 32'h3020);
    cyc();
    drv(1'b1, 32'h3100, 1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 32'd0);
    exp_out("eret_hold", 1'b0, 1'b0, HPC);
    rd(5'd12, "hold_sr", 32'h0000_0401);
    cyc();
    drv(1'b1, 32'h3104, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("post_hold_int", 1'b1, 1'b1, HPC);
    cyc(); idle();
    rd(5'd14, "post_hold_epc", 32'h3104);

    // MTC0 in a take cycle is discarded
    hw_int = 6'd0;
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'd0);
    exp_out("sr_clr2", 1'b0, 1'b0, HPC);
    cyc();
    drv(1'b1, 32'h6000, 1'b0, 5'd4, 1'b0, 1'b1, 5'd14, 32'hdead_beef);
    exp_out("take_we", 1'b1, 1'b1, HPC);
    cyc(); idle();
    rd(5'd14, "take_we_epc", 32'h6000);
    rd(5'd12, "take_we_sr", 32'h0000_0002);
    rd(5'd15, "prid", 32'h4D49_5053);
`ifdef EXC_COUNT_EN
    rd(5'd22, "cnt", 32'd5);
`else
    rd(5'd22, "cnt", 32'd0);
`endif

    // Cause and reg 22 writes
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 32'hffff_ffff);
    exp_out("cause_wr", 1'b0, 1'b0, HPC);
    cyc();
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd22, 32'h55);
    exp_out("cnt_wr", 1'b0, 1'b0, HPC);
    cyc(); idle();
    rd(5'd13, "cause_ro", 32'h0000_0010);
`ifdef EXC_COUNT_EN
    rd(5'd22, "cnt_load", 32'h55);
`else
    rd(5'd22, "cnt_load", 32'd0);
`endif

    // async reset in the middle of a take
    drv(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'd0);
    exp_out("sr_clr3", 1'b0, 1'b0, HPC);
    cyc();
    drv(1'b1, 32'h7000, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    exp_out("pre_rst_take", 1'b1, 1'b1, HPC);
    reset = 1'b0;
    exp_out("rst_mid", 1'b0, 1'b0, HPC);
    rd(5'd12, "rst_mid_sr", 32'd0);
    rd(5'd13, "rst_mid_cause", 32'd0);
    rd(5'd14, "rst_mid_epc", 32'd0);
    cyc(); idle();
    reset = 1'b1;
    cyc();

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
